// File: rtl/seq_pkg.sv
// Shared types and constants for the step sequencer.
// No logic; the event layout is the FIFO entry format.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int EV_NOTE_W = 7;
    localparam int MIN_TPS   = 2;
    localparam int MIN_GATE  = 1;

    typedef struct packed {
        logic                 on;
        logic [EV_NOTE_W-1:0] note;
    } event_t;

endpackage

// File: rtl/seq_event_fifo.sv
// 2-entry first-fall-through FIFO; head entry drives out_dat directly.
// Latency: a push is visible on out_vld the following cycle.
// Backpressure: in_rdy is low only when full and the head is not being popped.
module seq_event_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        full    = (count_q == 2'd2);
        empty   = (count_q == 2'd0);
        out_vld = !empty;
        out_dat = mem_q[rd_ptr_q];
        in_rdy  = !full || out_rdy;
        do_push = in_vld && in_rdy;
        do_pop  = out_vld && out_rdy;

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // When full, wr_ptr equals rd_ptr: the popped head is overwritten by the new entry.
        if (do_push) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Turns tempo pulses into note-on/off events from a 16-step pattern.
// Latency: event pushed on a pulse cycle is on ev_valid the next cycle.
// Backpressure: 2-entry event FIFO; overflow in RUN drops the event and sets overrun.
module step_sequencer
    import seq_pkg::*;
#(
    parameter int STEPS                 = 16,
    parameter int STEP_ADDR_W           = 4,
    parameter int NOTE_W                = EV_NOTE_W,
    parameter int TEMPO_RATE_DATA_WIDTH = 16,
    parameter int TICK_W                = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stop,
    input  logic [TEMPO_RATE_DATA_WIDTH-1:0] tempo_rate_cfg,
    input  logic [STEP_ADDR_W-1:0]           last_step,
    input  logic [TICK_W-1:0]                ticks_per_step,
    input  logic [TICK_W-1:0]                gate_ticks,
    input  logic                             pat_we,
    input  logic [STEP_ADDR_W-1:0]           pat_addr,
    input  logic [NOTE_W:0]                  pat_wdata,
    output logic                             tempo_enable,
    output logic [TEMPO_RATE_DATA_WIDTH-1:0] tempo_rate,
    input  logic                             tempo_pulse,
    output logic                             ev_valid,
    input  logic                             ev_ready,
    output logic [NOTE_W-1:0]                ev_note,
    output logic                             ev_on,
    output logic [STEP_ADDR_W-1:0]           step_idx,
    output logic                             busy,
    output logic                             overrun
);

    state_t                           state_q, state_d;
    logic [TEMPO_RATE_DATA_WIDTH-1:0] tempo_rate_q, tempo_rate_d;
    logic [STEP_ADDR_W-1:0]           last_step_q, last_step_d;
    logic [TICK_W-1:0]                tps_q, tps_d;
    logic [TICK_W-1:0]                gate_q, gate_d;
    logic [STEP_ADDR_W-1:0]           step_idx_q, step_idx_d;
    logic [TICK_W-1:0]                tick_cnt_q, tick_cnt_d;
    logic                             sounding_q, sounding_d;
    logic [NOTE_W-1:0]                note_q, note_d;
    logic                             overrun_q, overrun_d;
    logic [NOTE_W:0]                  pattern_q [STEPS];
    logic [NOTE_W:0]                  pattern_d [STEPS];

    logic [NOTE_W:0]    entry;
    logic [TICK_W-1:0]  tps_c, gate_lo, gate_c;
    logic               push_vld, push_rdy;
    event_t             push_dat, head;
    logic               fifo_full, fifo_empty;

    always_comb begin
        pattern_d = pattern_q;
        if (pat_we) begin
            pattern_d[pat_addr] = pat_wdata;
        end
    end

    always_comb begin
        tps_c   = (ticks_per_step < TICK_W'(MIN_TPS)) ? TICK_W'(MIN_TPS) : ticks_per_step;
        gate_lo = (gate_ticks < TICK_W'(MIN_GATE)) ? TICK_W'(MIN_GATE) : gate_ticks;
        // Gate strictly shorter than the step keeps note-off apart from the next note-on.
        gate_c  = (gate_lo > tps_c - TICK_W'(1)) ? tps_c - TICK_W'(1) : gate_lo;
        entry   = pattern_q[step_idx_q];

        state_d      = state_q;
        tempo_rate_d = tempo_rate_q;
        last_step_d  = last_step_q;
        tps_d        = tps_q;
        gate_d       = gate_q;
        step_idx_d   = step_idx_q;
        tick_cnt_d   = tick_cnt_q;
        sounding_d   = sounding_q;
        note_d       = note_q;
        overrun_d    = overrun_q;
        push_vld     = 1'b0;
        push_dat     = '0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    tempo_rate_d = tempo_rate_cfg;
                    last_step_d  = last_step;
                    tps_d        = tps_c;
                    gate_d       = gate_c;
                    overrun_d    = 1'b0;
                    step_idx_d   = '0;
                    tick_cnt_d   = '0;
                    sounding_d   = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = sounding_q ? DRAIN : IDLE;
                end else if (tempo_pulse) begin
                    if (tick_cnt_q == '0 && !entry[NOTE_W]) begin
                        push_vld      = 1'b1;
                        push_dat.on   = 1'b1;
                        push_dat.note = entry[NOTE_W-1:0];
                        sounding_d    = 1'b1;
                        note_d        = entry[NOTE_W-1:0];
                    end
                    if (tick_cnt_q == gate_q && sounding_q) begin
                        push_vld      = 1'b1;
                        push_dat.on   = 1'b0;
                        push_dat.note = note_q;
                        sounding_d    = 1'b0;
                    end
                    if (tick_cnt_q == tps_q - TICK_W'(1)) begin
                        tick_cnt_d = '0;
                        step_idx_d = (step_idx_q == last_step_q) ? '0
                                   : step_idx_q + STEP_ADDR_W'(1);
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                    if (push_vld && !push_rdy) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                push_vld      = 1'b1;
                push_dat.on   = 1'b0;
                push_dat.note = note_q;
                if (push_rdy) begin
                    sounding_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tempo_rate_q <= '0;
            last_step_q  <= '0;
            tps_q        <= '0;
            gate_q       <= '0;
            step_idx_q   <= '0;
            tick_cnt_q   <= '0;
            sounding_q   <= 1'b0;
            note_q       <= '0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < STEPS; i++) begin
                pattern_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tempo_rate_q <= tempo_rate_d;
            last_step_q  <= last_step_d;
            tps_q        <= tps_d;
            gate_q       <= gate_d;
            step_idx_q   <= step_idx_d;
            tick_cnt_q   <= tick_cnt_d;
            sounding_q   <= sounding_d;
            note_q       <= note_d;
            overrun_q    <= overrun_d;
            pattern_q    <= pattern_d;
        end
    end

    seq_event_fifo #(
        .W($bits(event_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (push_vld),
        .in_rdy  (push_rdy),
        .in_dat  (push_dat),
        .out_vld (ev_valid),
        .out_rdy (ev_ready),
        .out_dat (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev_on        = head.on;
    assign ev_note      = head.note;
    assign tempo_enable = (state_q == RUN);
    assign tempo_rate   = tempo_rate_q;
    assign step_idx     = step_idx_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: expected events are queued as pulses are
// driven and compared in order as the DUT hands them over.
module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stop, pat_we, tempo_pulse, ev_ready;
    logic [15:0] tempo_rate_cfg;
    logic [3:0]  last_step, pat_addr;
    logic [7:0]  ticks_per_step, gate_ticks, pat_wdata;
    logic        tempo_enable, ev_valid, ev_on, busy, overrun;
    logic [15:0] tempo_rate;
    logic [6:0]  ev_note;
    logic [3:0]  step_idx;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  tb_pat [16];
    int          tps_e, gate_e, last_e;

    always #5 clk = ~clk;

    step_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .tempo_rate_cfg (tempo_rate_cfg),
        .last_step      (last_step),
        .ticks_per_step (ticks_per_step),
        .gate_ticks     (gate_ticks),
        .pat_we         (pat_we),
        .pat_addr       (pat_addr),
        .pat_wdata      (pat_wdata),
        .tempo_enable   (tempo_enable),
        .tempo_rate     (tempo_rate),
        .tempo_pulse    (tempo_pulse),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_note        (ev_note),
        .ev_on          (ev_on),
        .step_idx       (step_idx),
        .busy           (busy),
        .overrun        (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            chk("ev_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("ev_data", {24'd0, ev_on, ev_note}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Closed-form expectation: pulse p falls on tick (p-1)%TPS of step ((p-1)/TPS)%(last+1).
    function automatic bit exp_ev(input int p, output logic [7:0] ev);
        int t, s;
        t  = (p - 1) % tps_e;
        s  = ((p - 1) / tps_e) % (last_e + 1);
        ev = '0;
        if (tb_pat[s][7]) return 1'b0;
        if (t == 0) begin
            ev = {1'b1, tb_pat[s][6:0]};
            return 1'b1;
        end
        if (t == gate_e) begin
            ev = {1'b0, tb_pat[s][6:0]};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic expect_pulse(input int p);
        logic [7:0] e;
        if (exp_ev(p, e)) exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        tempo_pulse = 1'b1;
        cyc(1);
        tempo_pulse = 1'b0;
        cyc(1);
    endtask

    task automatic wr_pat(input logic [3:0] a, input logic [7:0] d);
        pat_we    = 1'b1;
        pat_addr  = a;
        pat_wdata = d;
        tb_pat[a] = d;
        cyc(1);
        pat_we    = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] r, input logic [3:0] l,
                            input logic [7:0] t, input logic [7:0] g);
        tempo_rate_cfg = r;
        last_step      = l;
        ticks_per_step = t;
        gate_ticks     = g;
        start          = 1'b1;
        cyc(1);
        start          = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc(1);
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pat_we = 1'b0; tempo_pulse = 1'b0;
        ev_ready = 1'b0; tempo_rate_cfg = '0; last_step = '0; pat_addr = '0;
        ticks_per_step = '0; gate_ticks = '0; pat_wdata = '0;
        for (int i = 0; i < 16; i++) tb_pat[i] = '0;
        cyc(2);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_tempo_en", tempo_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_tempo_rate", tempo_rate, 0);
        reset = 1'b0;
        cyc(1);

        wr_pat(4'd0, 8'd60);
        wr_pat(4'd1, 8'd62);
        wr_pat(4'd2, 8'h80);
        wr_pat(4'd3, 8'd64);

        // Basic sequence with wrap
        tps_e = 4; gate_e = 2; last_e = 3;
        ev_ready = 1'b1;
        do_start(16'h1234, 4'd3, 8'd4, 8'd2);
        chk("basic_rate", tempo_rate, 16'h1234);
        chk("basic_tempo_en", tempo_enable, 1);
        chk("basic_busy", busy, 1);
        for (int p = 1; p <= 17; p++) begin
            expect_pulse(p);
            pulse();
            if (p % 4 == 0) chk("basic_step_idx", step_idx, (p / 4) % 4);
        end
        wait_drain("basic_drain");
        exp_q.push_back({1'b0, 7'd60});
        do_stop();
        chk("basic_stop_en", tempo_enable, 0);
        wait_drain("basic_stop_off");
        cyc(1);
        chk("basic_idle", busy, 0);

        // Clamping: TPS 0 -> 2, GATE 9 -> 1
        tps_e = 2; gate_e = 1; last_e = 1;
        do_start(16'h0042, 4'd1, 8'd0, 8'd9);
        chk("clamp_rate", tempo_rate, 16'h0042);
        for (int p = 1; p <= 8; p++) begin
            expect_pulse(p);
            pulse();
        end
        wait_drain("clamp_drain");
        do_stop();
        cyc(1);
        chk("clamp_idle", busy, 0);

        // Backpressure: third event dropped, DRAIN waits for space
        tps_e = 4; gate_e = 2; last_e = 3;
        ev_ready = 1'b0;
        do_start(16'h0100, 4'd3, 8'd4, 8'd2);
        for (int p = 1; p <= 4; p++) begin
            expect_pulse(p);
            pulse();
        end
        chk("bp_no_overrun_yet", overrun, 0);
        pulse();
        chk("bp_overrun", overrun, 1);
        exp_q.push_back({1'b0, 7'd62});
        do_stop();
        cyc(2);
        chk("bp_drain_busy", busy, 1);
        chk("bp_drain_tempo_en", tempo_enable, 0);
        chk("bp_head", {ev_valid, ev_on, ev_note}, {2'b11, 7'd60});
        ev_ready = 1'b1;
        wait_drain("bp_drain");
        cyc(1);
        chk("bp_idle", busy, 0);
        chk("bp_overrun_sticky", overrun, 1);
        do_start(16'h0100, 4'd3, 8'd4, 8'd2);
        chk("bp_overrun_clr", overrun, 0);
        do_stop();
        cyc(1);

        // Stop mid-note with downstream stalled
        ev_ready = 1'b0;
        do_start(16'h0200, 4'd3, 8'd4, 8'd2);
        expect_pulse(1);
        pulse();
        exp_q.push_back({1'b0, 7'd60});
        do_stop();
        chk("stop_drain_busy", busy, 1);
        chk("stop_tempo_en", tempo_enable, 0);
        tempo_pulse = 1'b1;
        cyc(1);
        tempo_pulse = 1'b0;
        chk("stop_idle_after_push", busy, 0);
        ev_ready = 1'b1;
        wait_drain("stop_drain");

        // Simultaneous / ignored requests
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("both_busy", busy, 0);
        chk("both_tempo_en", tempo_enable, 0);
        do_start(16'hABCD, 4'd3, 8'd4, 8'd2);
        do_start(16'h5555, 4'd0, 8'd2, 8'd1);
        chk("restart_rate", tempo_rate, 16'hABCD);
        chk("restart_busy", busy, 1);
        for (int p = 1; p <= 5; p++) begin
            expect_pulse(p);
            pulse();
        end
        wait_drain("restart_drain");

        // Reset during RUN with queued events
        ev_ready = 1'b0;
        for (int p = 6; p <= 8; p++) pulse();
        chk("pre_rst_step", step_idx, 2);
        chk("pre_rst_valid", ev_valid, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_valid", ev_valid, 0);
        chk("mid_rst_tempo_en", tempo_enable, 0);
        chk("mid_rst_step", step_idx, 0);
        chk("mid_rst_busy", busy, 0);
        cyc(3);
        chk("mid_rst_no_off", ev_valid, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
